bgjank_rom_arbiter: RTL and testbench
=====================================

// Module: bgjank_rom_arbiter
// PURPOSE
//  Shares the single-port background ROM (bgjank_rom, 1-cycle registered read) between VGA
//  scanout and a game-logic requester (tower-placement / path-hit lookup). Scanout owns the port
//  during active display; game reads are served in blanking via req/ack. Sits between the
//  DrawX/DrawY generator and bgjank_rom/bgjank_palette; the top RGB register consumes its outputs.
// PARAMETERS
//  IMG_W   320  background width in texels
//  IMG_H   240  background height in texels
//  SHIFT   1    screen-to-texel downscale (DrawX>>SHIFT, DrawY>>SHIFT)
//  ADDR_W  17   ROM address width
//  IDX_W   4    palette index width
// PORTS
//  vga_clk      in   1       sole clock
//  reset        in   1       asynchronous, active-high
//  DrawX        in   10      scan pixel X
//  DrawY        in   10      scan pixel Y
//  blank        in   1       1 = active display region, 0 = blanking
//  req          in   1       game read request; held with x/y stable until ack
//  req_x        in   9       texel X (0..IMG_W-1 valid)
//  req_y        in   8       texel Y (0..IMG_H-1 valid)
//  ack          out  1       one-cycle pulse: rdata/oob valid
//  rdata        out  IDX_W   palette index read for the requester
//  oob          out  1       with ack: coordinates out of range, rdata=0
//  rom_address  out  ADDR_W  to bgjank_rom.address (combinational mux)
//  rom_q        in   IDX_W   from bgjank_rom.q (address of previous cycle)
//  bg_index     out  IDX_W   = rom_q, to palette
//  bg_valid     out  1       registered: bg_index is a scanout texel and blank was 1 last cycle
// BEHAVIOUR
//  - Reset (async): state=IDLE; ack=0, rdata=0, oob=0, bg_valid=0, owner_d=VGA.
//  - Address: scan = (DrawX>>SHIFT) + (DrawY>>SHIFT)*IMG_W; game = req_x + req_y*IMG_W.
//    Products computed at ADDR_W bits, no truncation for in-range inputs.
//  - Mux: rom_address = game address only in the cycle state==IDLE & req & !blank & in-range;
//    otherwise scan address. Scanout always wins when blank=1; a game read is never issued then.
//  - owner_d registered each cycle (GAME if game address issued, else VGA); bg_valid <= (owner
//    this cycle==VGA) & blank. Scanout latency DrawX/Y -> bg_index = 1 cycle, identical to direct ROM.
//  - FSM (states in package):
//    IDLE: req & !blank & in-range -> READ (address issued this cycle).
//          req & !blank & out-of-range -> READ with oob_pend=1, no ROM access.
//          req & blank -> stay IDLE (wait for blanking).
//    READ: rdata <= oob_pend ? 0 : rom_q; oob <= oob_pend; ack <= 1 -> DONE.
//    DONE: ack <= 0; stay until req==0, then IDLE (prevents double service of held req).
//  - Latency: req sampled in blanking at cycle N -> ack high during cycle N+2.
//  - blank rising during READ: game data already in rom_q, capture proceeds; scan address issued
//    that cycle, so scanout is unaffected.
//  - req dropped before ack: transaction completes, ack still pulses once; DONE exits next cycle.
//  - Starvation bound: 160 blank cycles per 800-cycle line -> worst-case wait < 1 line + 2 cycles.
//  - reset mid-transaction: abort, no ack, outputs to reset values.
// STRUCTURE
//  - bgjank_pkg: IMG_W, IMG_H, SHIFT, ADDR_W, IDX_W constants; arb_state_t enum {IDLE,READ,DONE};
//    owner_t enum {OWN_VGA,OWN_GAME}.
//  - Sub-module bg_addr_calc (combinational: x,y -> address, in_range); instantiated twice
//    (scan, game). Arbiter FSM and output registers live in this module.
// TESTING
//  - Scanout only (req=0): DrawX=3,DrawY=5,blank=1 -> rom_address=1+2*320=641; bg_valid=1 next cycle.
//  - Game read in blanking: blank=0, req=1, (10,20) -> rom_address=6410 at N; ack=1, rdata=ROM[6410]
//    at N+2, oob=0; ack single cycle while req held high.
//  - Held-off read: req=1 with blank=1 for 640 cycles -> no game address issued, then served
//    on first blank=0 cycle, ack 2 cycles later; scan addresses uninterrupted.
//  - Out of range: req_x=320 -> ack at N+2, oob=1, rdata=0, rom_address stays scan address.
//  - blank rises in READ cycle: rdata equals game texel; next bg_index equals scan texel, bg_valid=1.
//  - reset asserted in READ: ack never pulses, state IDLE, all outputs 0 immediately (async).

Source files
------------

// File: rtl/bgjank_pkg.sv
// Shared constants and state/ownership types for the background ROM arbiter.
package bgjank_pkg;

    // Background image geometry and screen-to-texel downscale
    localparam int IMG_W   = 320;
    localparam int IMG_H   = 240;
    localparam int SHIFT   = 1;

    // ROM interface widths
    localparam int ADDR_W  = 17;
    localparam int IDX_W   = 4;

    // Coordinate port widths
    localparam int SCAN_W  = 10;
    localparam int REQ_X_W = 9;
    localparam int REQ_Y_W = 8;

    // Game-request FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Which requester drove the ROM address in a given cycle
    typedef enum logic {
        OWN_VGA  = 1'b0,
        OWN_GAME = 1'b1
    } owner_t;

endpackage

// File: rtl/bg_addr_calc.sv
// Combinational texel-coordinate to linear ROM address, with an on-image flag.
module bg_addr_calc
    import bgjank_pkg::*;
#(
    parameter int X_W = SCAN_W,
    parameter int Y_W = SCAN_W,
    parameter int SH  = SHIFT
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    logic [ADDR_W-1:0] tx;
    logic [ADDR_W-1:0] ty;

    // Downscale, widen to the address width, then row-major linearise
    always_comb begin
        tx       = ADDR_W'(x >> SH);
        ty       = ADDR_W'(y >> SH);
        addr     = tx + ty * ADDR_W'(IMG_W);
        in_range = (tx < ADDR_W'(IMG_W)) && (ty < ADDR_W'(IMG_H));
    end

endmodule

// File: rtl/bgjank_rom_arbiter.sv
// Shares the single-port background ROM between VGA scanout (active display)
// and a game-logic requester served only during blanking via req/ack.
module bgjank_rom_arbiter
    import bgjank_pkg::*;
(
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              req,
    input  logic [8:0]        req_x,
    input  logic [7:0]        req_y,
    output logic              ack,
    output logic [IDX_W-1:0]  rdata,
    output logic              oob,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  bg_index,
    output logic              bg_valid
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            owner_now;
    owner_t            owner_d;
    logic              oob_pend;
    logic              req_service;
    logic              game_issue;

    logic [ADDR_W-1:0] scan_addr;
    logic              scan_in_range;
    logic [ADDR_W-1:0] game_addr;
    logic              game_in_range;

    bg_addr_calc #(
        .X_W (SCAN_W),
        .Y_W (SCAN_W),
        .SH  (SHIFT)
    ) u_scan_addr (
        .x        (DrawX),
        .y        (DrawY),
        .addr     (scan_addr),
        .in_range (scan_in_range)
    );

    bg_addr_calc #(
        .X_W (REQ_X_W),
        .Y_W (REQ_Y_W),
        .SH  (0)
    ) u_game_addr (
        .x        (req_x),
        .y        (req_y),
        .addr     (game_addr),
        .in_range (game_in_range)
    );

    // Palette index passes straight through; ROM already registers the read
    assign bg_index = rom_q;

    // FSM state register
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a request is only accepted in blanking, and DONE
    // waits for req to drop so a held request is never served twice
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_service) state_nxt = READ;
            READ:    state_nxt = DONE;
            DONE:    if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ROM port ownership and address mux for this cycle
    always_comb begin
        req_service = (state == IDLE) && req && !blank;
        game_issue  = req_service && game_in_range;
        owner_now   = game_issue ? OWN_GAME : OWN_VGA;
        rom_address = game_issue ? game_addr : scan_addr;
    end

    // Output and bookkeeping registers; in READ the ROM already holds the
    // game texel, so capture is unaffected by blank rising that cycle
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ack      <= 1'b0;
            rdata    <= '0;
            oob      <= 1'b0;
            oob_pend <= 1'b0;
            bg_valid <= 1'b0;
            owner_d  <= OWN_VGA;
        end else begin
            owner_d  <= owner_now;
            bg_valid <= (owner_now == OWN_VGA) && blank;
            ack      <= 1'b0;
            if (req_service) begin
                oob_pend <= !game_in_range;
            end
            if (state == READ) begin
                ack   <= 1'b1;
                oob   <= oob_pend;
                rdata <= (oob_pend || (owner_d != OWN_GAME)) ? '0 : rom_q;
            end
        end
    end

    // Active-display scan coordinates must always map onto the image
    always_ff @(posedge vga_clk) begin
        if (!reset && blank) begin
            assert (scan_in_range);
        end
    end

endmodule

// File: tb/tb_bgjank_rom_arbiter.sv
// Directed-vector bench with a scoreboard for game-read acknowledgements.
module tb_bgjank_rom_arbiter;

    logic        vga_clk;
    logic        reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        req;
    logic [8:0]  req_x;
    logic [7:0]  req_y;
    logic        ack;
    logic [3:0]  rdata;
    logic        oob;
    logic [16:0] rom_address;
    logic [3:0]  rom_q;
    logic [3:0]  bg_index;
    logic        bg_valid;

    typedef struct {
        logic [3:0] rdata;
        logic       oob;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    bgjank_rom_arbiter dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .ack         (ack),
        .rdata       (rdata),
        .oob         (oob),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .bg_index    (bg_index),
        .bg_valid    (bg_valid)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ROM contents: low nibble XOR second nibble of the address
    function automatic logic [3:0] rom_fn(input logic [16:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge vga_clk);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge vga_clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got ack=1 expected no pending read");
            end else begin
                e = exp_q.pop_front();
                check("ack_rdata", 32'(rdata), 32'(e.rdata));
                check("ack_oob", 32'(oob), 32'(e.oob));
            end
        end
    end

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        req = 1'b0; req_x = '0; req_y = '0;

        // Reset state
        mid();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_oob", 32'(oob), 32'd0);
        check("rst_bg_valid", 32'(bg_valid), 32'd0);

        // Scanout only: (3,5) -> 1 + 2*320 = 641, ROM[641] = 9
        next_cycle(); reset = 1'b0; blank = 1'b1; DrawX = 10'd3; DrawY = 10'd5;
        mid(); check("scan_addr", 32'(rom_address), 32'd641);
        next_cycle();
        mid();
        check("scan_bg_valid", 32'(bg_valid), 32'd1);
        check("scan_bg_index", 32'(bg_index), 32'h9);

        // Game read in blanking: (10,20) -> 6410, ROM = A; req held well past ack
        next_cycle(); blank = 1'b0; req = 1'b1; req_x = 9'd10; req_y = 8'd20;
        exp_q.push_back('{4'hA, 1'b0});
        mid(); check("game_addr", 32'(rom_address), 32'd6410);
        check("game_ack_n", 32'(ack), 32'd0);
        next_cycle(); mid(); check("game_ack_n1", 32'(ack), 32'd0);
        next_cycle(); mid(); check("game_ack_n2", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); mid(); check("game_ack_held", 32'(ack), 32'd0);
        end
        next_cycle(); req = 1'b0;
        next_cycle();

        // Held-off read: (7,1) -> 327, ROM = 3; 640 active cycles first
        for (int i = 0; i < 640; i++) begin
            next_cycle(); blank = 1'b1; DrawX = 10'(i); DrawY = 10'd10;
            req = 1'b1; req_x = 9'd7; req_y = 8'd1;
            mid(); check("held_scan_addr", 32'(rom_address), 32'((i >> 1) + 1600));
        end
        next_cycle(); blank = 1'b0;
        exp_q.push_back('{4'h3, 1'b0});
        mid(); check("held_game_addr", 32'(rom_address), 32'd327);
        next_cycle(); mid(); check("held_ack_n1", 32'(ack), 32'd0);
        next_cycle(); mid(); check("held_ack_n2", 32'(ack), 32'd1);
        next_cycle(); req = 1'b0;
        next_cycle();

        // Out of range x=320, req dropped before ack; scan (20,4) -> 650
        next_cycle(); blank = 1'b0; req = 1'b1; req_x = 9'd320; req_y = 8'd0;
        DrawX = 10'd20; DrawY = 10'd4;
        exp_q.push_back('{4'h0, 1'b1});
        mid(); check("oob_scan_addr", 32'(rom_address), 32'd650);
        next_cycle(); req = 1'b0;
        mid(); check("oob_ack_n1", 32'(ack), 32'd0);
        next_cycle(); mid();
        check("oob_ack_n2", 32'(ack), 32'd1);
        check("oob_flag", 32'(oob), 32'd1);
        check("oob_rdata", 32'(rdata), 32'd0);
        next_cycle(); mid(); check("oob_ack_after", 32'(ack), 32'd0);
        next_cycle();

        // Blank rises in READ: game (2,3) -> 962, ROM = E; scan (40,2) -> 340, ROM = 1
        next_cycle(); blank = 1'b0; req = 1'b1; req_x = 9'd2; req_y = 8'd3;
        exp_q.push_back('{4'hE, 1'b0});
        mid(); check("rise_game_addr", 32'(rom_address), 32'd962);
        next_cycle(); blank = 1'b1; DrawX = 10'd40; DrawY = 10'd2;
        mid(); check("rise_scan_addr", 32'(rom_address), 32'd340);
        next_cycle(); mid();
        check("rise_ack", 32'(ack), 32'd1);
        check("rise_bg_index", 32'(bg_index), 32'h1);
        check("rise_bg_valid", 32'(bg_valid), 32'd1);
        next_cycle(); req = 1'b0; blank = 1'b0;
        next_cycle();

        // Reset asserted in READ: (1,1) -> 321; no ack, outputs cleared at once
        next_cycle(); blank = 1'b0; req = 1'b1; req_x = 9'd1; req_y = 8'd1;
        mid(); check("rstmid_addr", 32'(rom_address), 32'd321);
        next_cycle(); reset = 1'b1;
        #1;
        check("rstmid_ack", 32'(ack), 32'd0);
        check("rstmid_rdata", 32'(rdata), 32'd0);
        check("rstmid_oob", 32'(oob), 32'd0);
        check("rstmid_bg_valid", 32'(bg_valid), 32'd0);
        req = 1'b0;
        next_cycle();
        next_cycle(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); mid(); check("rstmid_no_ack", 32'(ack), 32'd0);
        end

        // FSM back in IDLE: same request is accepted immediately; ROM[321] = 5
        next_cycle(); req = 1'b1;
        exp_q.push_back('{4'h5, 1'b0});
        mid(); check("post_rst_addr", 32'(rom_address), 32'd321);
        next_cycle();
        next_cycle(); mid(); check("post_rst_ack", 32'(ack), 32'd1);
        next_cycle(); req = 1'b0;
        next_cycle(); next_cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
